mem_bus_responder: RTL and testbench

- Target-side model of the byte-serial memory bus driven by the CPU memory controller.
- Owns a byte-addressed RAM and an IO window at address[17:16]==2'b11.
- IO window holds a UART-style TX FIFO, an RX FIFO and a program-end register.
- Returns read bytes with one-cycle latency and raises io_buffer_full as TX backpressure to the controller.

---
 rtl/mem_bus_responder_if.sv | 25 ++
 rtl/mem_bus_responder.sv | 127 ++++++++++++
 tb/tb_mem_bus_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// Byte-serial memory bus between the CPU memory controller (master) and the
// target-side responder (slave).
interface mem_bus_responder_if;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;

    modport master (
        output bus_a,
        output bus_wr,
        output bus_wdata,
        input  bus_rdata,
        input  io_buffer_full
    );

    modport slave (
        input  bus_a,
        input  bus_wr,
        input  bus_wdata,
        output bus_rdata,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Target side of the controller's byte bus: byte RAM plus an IO window holding
// TX/RX FIFOs and a program-end register, with one-cycle read latency.
module mem_bus_responder #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned RX_DEPTH    = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    mem_bus_responder_if.slave  bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                prog_end,
    output logic [7:0]          end_code,
    output logic                tx_overflow
);

    localparam int unsigned RAM_SIZE = 2 ** ADDR_W;
    localparam int unsigned TX_PW    = $clog2(TX_DEPTH);
    localparam int unsigned RX_PW    = $clog2(RX_DEPTH);

    localparam logic [17:0]    IO_DATA   = 18'h30000;
    localparam logic [17:0]    IO_END    = 18'h30004;
    localparam logic [TX_PW:0] TX_ONE    = 1;
    localparam logic [RX_PW:0] RX_ONE    = 1;
    localparam logic [TX_PW:0] TX_THRESH = (TX_PW + 1)'(TX_DEPTH - FULL_MARGIN);

    logic [7:0] ram    [RAM_SIZE];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TX_PW:0] tx_wptr, tx_rptr, tx_count;
    logic [RX_PW:0] rx_wptr, rx_rptr;
    logic           tx_full, tx_empty, rx_full, rx_empty;

    logic [ADDR_W-1:0] ram_idx;
    logic [17:0]       dec_a;
    logic              is_io, acc;
    logic              ram_we, tx_push_req, tx_push, tx_pop;
    logic              rx_push, rx_pop, end_we;
    logic [7:0]        io_rdata;
    logic [7:0]        rdata_q;
    logic              unused_addr;

    assign unused_addr = ^bus.bus_a[31:18];

    assign dec_a   = bus.bus_a[17:0];
    assign ram_idx = bus.bus_a[ADDR_W-1:0];
    assign is_io   = (dec_a[17:16] == 2'b11);
    // Bus side only acts when the system is ready and not in reset.
    assign acc     = rdy && !rst;

    assign tx_count = tx_wptr - tx_rptr;
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_PW] != tx_rptr[TX_PW]) &&
                      (tx_wptr[TX_PW-1:0] == tx_rptr[TX_PW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[RX_PW] != rx_rptr[RX_PW]) &&
                      (rx_wptr[RX_PW-1:0] == rx_rptr[RX_PW-1:0]);

    assign ram_we      = acc && bus.bus_wr && !is_io;
    assign tx_push_req = acc && bus.bus_wr && (dec_a == IO_DATA);
    assign tx_push     = tx_push_req && !tx_full;
    assign end_we      = acc && bus.bus_wr && (dec_a == IO_END);
    assign rx_pop      = acc && !bus.bus_wr && (dec_a == IO_DATA) && !rx_empty;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rptr[TX_PW-1:0]];
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;

    assign bus.io_buffer_full = (tx_count >= TX_THRESH);
    assign bus.bus_rdata      = rdata_q;

    always_comb begin
        io_rdata = 8'h00;
        if (dec_a == IO_DATA) begin
            io_rdata = rx_empty ? 8'h00 : rx_mem[rx_rptr[RX_PW-1:0]];
        end else if (dec_a == IO_END) begin
            io_rdata = {6'b0, rx_empty, tx_empty};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.bus_wdata;
        end
        if (tx_push) begin
            tx_mem[tx_wptr[TX_PW-1:0]] <= bus.bus_wdata;
        end
        if (rx_push && !rst) begin
            rx_mem[rx_wptr[RX_PW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q     <= 8'h00;
            prog_end    <= 1'b0;
            end_code    <= 8'h00;
            tx_overflow <= 1'b0;
            tx_wptr     <= '0;
            tx_rptr     <= '0;
            rx_wptr     <= '0;
            rx_rptr     <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
            if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
            if (tx_push_req && tx_full) tx_overflow <= 1'b1;
            prog_end <= end_we;
            if (end_we) end_code <= bus.bus_wdata;
            if (rdy && !bus.bus_wr) begin
                rdata_q <= is_io ? io_rdata : ram[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM access, TX/RX FIFOs, program end,
// rdy stalls and reset.
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       prog_end;
    logic [7:0] end_code;
    logic       tx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_responder_if bus_if ();

    mem_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .bus         (bus_if),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .prog_end    (prog_end),
        .end_code    (end_code),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus_if.bus_a  = a;
        bus_if.bus_wr = 1'b0;
        step();
    endtask

    task automatic bus_wrb(input logic [31:0] a, input logic [7:0] d);
        bus_if.bus_a     = a;
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_wdata = d;
        step();
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_a     = 32'h100;
    endtask

    logic [7:0] pat [4];

    initial begin
        pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56; pat[3] = 8'h78;
        rst = 1'b1; rdy = 1'b1;
        bus_if.bus_a = 32'h0; bus_if.bus_wr = 1'b0; bus_if.bus_wdata = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(); step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_rdata", bus_if.bus_rdata, 32'h0);
        check_eq("rst_tx_valid", tx_valid, 32'h0);
        check_eq("rst_rx_ready", rx_ready, 32'h1);
        check_eq("rst_iofull", bus_if.io_buffer_full, 32'h0);
        check_eq("rst_prog_end", prog_end, 32'h0);
        check_eq("rst_end_code", end_code, 32'h0);
        check_eq("rst_overflow", tx_overflow, 32'h0);

        // RAM write then read back
        for (int i = 0; i < 4; i++) bus_wrb(32'h100 + i, pat[i]);
        for (int i = 0; i < 4; i++) begin
            bus_rd(32'h100 + i);
            check_eq($sformatf("ram_rd%0d", i), bus_if.bus_rdata, {24'h0, pat[i]});
        end
        bus_wrb(32'h104, 8'h55);
        bus_rd(32'h104);
        check_eq("ram_raw", bus_if.bus_rdata, 32'h55);
        // [17:16]=2'b10 is RAM and aliases index 0x00005
        bus_wrb(32'h20005, 8'h9C);
        bus_rd(32'h00005);
        check_eq("ram_wrap", bus_if.bus_rdata, 32'h9C);

        // TX fill, backpressure, overflow and drain
        for (int i = 0; i < 9; i++) begin
            bus_wrb(32'h30000, 8'hA0 + 8'(i));
            if (i == 4) check_eq("tx_full5", bus_if.io_buffer_full, 32'h0);
            if (i == 5) check_eq("tx_full6", bus_if.io_buffer_full, 32'h1);
            if (i == 7) check_eq("tx_ovf8", tx_overflow, 32'h0);
        end
        check_eq("tx_ovf9", tx_overflow, 32'h1);
        check_eq("tx_head", tx_data, 32'hA0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("tx_drain%0d", i), tx_data, 32'hA0 + i);
            step();
        end
        tx_ready = 1'b0;
        check_eq("tx_empty", tx_valid, 32'h0);
        check_eq("tx_iofull_clr", bus_if.io_buffer_full, 32'h0);
        check_eq("tx_ovf_sticky", tx_overflow, 32'h1);

        // RX single byte, IO reads with bubble, status
        rx_data = 8'h41; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        bus_rd(32'h30004);
        check_eq("st_rx1", bus_if.bus_rdata, 32'h01);
        bus_rd(32'h30000);
        check_eq("rx_pop1", bus_if.bus_rdata, 32'h41);
        bus_rd(32'h100);
        bus_rd(32'h30000);
        check_eq("rx_pop_empty", bus_if.bus_rdata, 32'h00);
        bus_rd(32'h30004);
        check_eq("st_empty", bus_if.bus_rdata, 32'h03);

        // Pop from empty in the same cycle as an external push
        rx_data = 8'h77; rx_valid = 1'b1;
        bus_rd(32'h30000);
        rx_valid = 1'b0;
        check_eq("rx_same_rd", bus_if.bus_rdata, 32'h00);
        bus_rd(32'h100);
        bus_rd(32'h30000);
        check_eq("rx_same_push", bus_if.bus_rdata, 32'h77);

        // RX fill to full, refused push, drain in order
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'hB0 + 8'(i);
            bus_rd(32'h100);
        end
        rx_valid = 1'b0;
        check_eq("rx_full", rx_ready, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_rd(32'h30000);
            check_eq($sformatf("rx_drain%0d", i), bus_if.bus_rdata, 32'hB0 + i);
            if (i == 0) check_eq("rx_ready_again", rx_ready, 32'h1);
            bus_rd(32'h100);
        end
        bus_rd(32'h30000);
        check_eq("rx_refused", bus_if.bus_rdata, 32'h00);

        // Program end
        bus_wrb(32'h30004, 8'h2A);
        check_eq("pe_pulse", prog_end, 32'h1);
        check_eq("pe_code", end_code, 32'h2A);
        step();
        check_eq("pe_low", prog_end, 32'h0);
        check_eq("pe_code_hold", end_code, 32'h2A);

        // rdy=0 freezes the bus side
        bus_wrb(32'h200, 8'h11);
        bus_rd(32'h100);
        rdy = 1'b0;
        bus_wrb(32'h200, 8'hFF);
        check_eq("rdy0_hold", bus_if.bus_rdata, 32'h12);
        bus_wrb(32'h30000, 8'hEE);
        check_eq("rdy0_no_tx", tx_valid, 32'h0);
        rdy = 1'b1;
        bus_rd(32'h200);
        check_eq("rdy0_no_wr", bus_if.bus_rdata, 32'h11);
        bus_wrb(32'h200, 8'hFF);
        bus_rd(32'h200);
        check_eq("rdy1_wr", bus_if.bus_rdata, 32'hFF);

        // Reset mid-transfer discards FIFOs
        for (int i = 0; i < 3; i++) bus_wrb(32'h30000, 8'hC0 + 8'(i));
        rx_data = 8'h99; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check_eq("pre_rst_txv", tx_valid, 32'h1);
        bus_rd(32'h100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("post_rst_txv", tx_valid, 32'h0);
        check_eq("post_rst_iofull", bus_if.io_buffer_full, 32'h0);
        check_eq("post_rst_rdata", bus_if.bus_rdata, 32'h0);
        check_eq("post_rst_ovf", tx_overflow, 32'h0);
        bus_rd(32'h30000);
        check_eq("post_rst_io_rd", bus_if.bus_rdata, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
